// File: rtl/sequencer_vmoncompare_pkg.sv
// sequencer_vmoncompare_pkg: shared channel states, thresholds and the code classifier
// Contents: vmon_state_t, P_MAX_RAILS, VIN/VOUT UV/OV thresholds, P_VMON_HYST, vmon_classify().
package sequencer_vmoncompare_pkg;
  typedef enum logic [1:0] {ST_UNKNOWN, ST_LOW, ST_GOOD, ST_HIGH} vmon_state_t;
  localparam int P_MAX_RAILS = 16;
  localparam logic [12:0] P_VIN_UV_TH = 13'h600;
  localparam logic [12:0] P_VIN_OV_TH = 13'hA00;
  localparam logic [12:0] P_VOUT_UV_TH [P_MAX_RAILS] = '{default: 13'h600};
  localparam logic [12:0] P_VOUT_OV_TH [P_MAX_RAILS] = '{default: 13'hA00};
  localparam logic [12:0] P_VMON_HYST = 13'h020;
  // ST_UNKNOWN is returned for the hysteresis band: "no new opinion, keep current state".
  // Sums are formed at 14 bits so large thresholds never wrap.
  function automatic vmon_state_t vmon_classify(input logic [11:0] code, input logic [12:0] uv_th,
                                                input logic [12:0] ov_th, input logic [12:0] hyst);
    logic [13:0] c;
    c = {2'b00, code};
    if (c < 14'(uv_th)) return ST_LOW;
    if (c > 14'(ov_th)) return ST_HIGH;
    if (c >= 14'(uv_th) + 14'(hyst) && c + 14'(hyst) <= 14'(ov_th)) return ST_GOOD;
    return ST_UNKNOWN;
  endfunction
endpackage

// File: rtl/sequencer_vmoncompare_if.sv
// sequencer_vmoncompare_if: ADC level inputs and status outputs of the vmon compare block
// Signals: ADC_VIN_LEVEL_Q/ADC_VOUT_LEVEL_Q {ever-valid, strobe, code}, FAULT_CLR,
//   VIN_GOOD/VIN_UV, RAIL_GOOD/RAIL_UV/RAIL_OV, FAULT_STICKY, ADC_STALE (VMON_TIMEOUT_EN only).
// Modports: master drives levels/clear, slave (the compare block) drives status.
interface sequencer_vmoncompare_if #(parameter int VRAILS = 4);
  logic [13:0]          ADC_VIN_LEVEL_Q;
  logic [VRAILS*14-1:0] ADC_VOUT_LEVEL_Q;
  logic                 FAULT_CLR;
  logic                 VIN_GOOD;
  logic                 VIN_UV;
  logic [VRAILS-1:0]    RAIL_GOOD;
  logic [VRAILS-1:0]    RAIL_UV;
  logic [VRAILS-1:0]    RAIL_OV;
  logic                 FAULT_STICKY;
`ifdef VMON_TIMEOUT_EN
  logic [VRAILS:0]      ADC_STALE;
  modport master (output ADC_VIN_LEVEL_Q, ADC_VOUT_LEVEL_Q, FAULT_CLR,
                  input VIN_GOOD, VIN_UV, RAIL_GOOD, RAIL_UV, RAIL_OV, FAULT_STICKY, ADC_STALE);
  modport slave (input ADC_VIN_LEVEL_Q, ADC_VOUT_LEVEL_Q, FAULT_CLR,
                 output VIN_GOOD, VIN_UV, RAIL_GOOD, RAIL_UV, RAIL_OV, FAULT_STICKY, ADC_STALE);
`else
  modport master (output ADC_VIN_LEVEL_Q, ADC_VOUT_LEVEL_Q, FAULT_CLR,
                  input VIN_GOOD, VIN_UV, RAIL_GOOD, RAIL_UV, RAIL_OV, FAULT_STICKY);
  modport slave (input ADC_VIN_LEVEL_Q, ADC_VOUT_LEVEL_Q, FAULT_CLR,
                 output VIN_GOOD, VIN_UV, RAIL_GOOD, RAIL_UV, RAIL_OV, FAULT_STICKY);
`endif
endinterface

// File: rtl/sequencer_vmon_chan.sv
// sequencer_vmon_chan: one monitored channel -- classify, debounce, state FSM, optional stale timeout
// Ports: CLOCK, RESET_N (async, active-low); level_q {ever-valid, strobe, code[11:0]};
//   uv_th/ov_th thresholds; state = current channel state; fault_set = GOOD left for LOW/HIGH
//   (or went stale); stale = no strobe for TIMEOUT_CLKS clocks (VMON_TIMEOUT_EN only).
module sequencer_vmon_chan
  import sequencer_vmoncompare_pkg::*;
#(
  parameter int SAMPLE_DB = 3
`ifdef VMON_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CLKS = 4096
`endif
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [13:0] level_q,
  input  logic [12:0] uv_th,
  input  logic [12:0] ov_th,
  output vmon_state_t state,
  output logic        fault_set
`ifdef VMON_TIMEOUT_EN
  ,
  output logic        stale
`endif
);
  localparam int CW = $clog2(SAMPLE_DB + 1);
  logic eval, sw;
  vmon_state_t cls, cand;
  logic [CW-1:0] cnt, cnt_nxt;
  assign eval = level_q[13] & level_q[12];
  assign cls = vmon_classify(level_q[11:0], uv_th, ov_th, P_VMON_HYST);
  always_comb begin
    cnt_nxt = cls == ST_UNKNOWN ? '0 : cls != cand ? CW'(1) : cnt == CW'(SAMPLE_DB) ? cnt : cnt + CW'(1);
    sw = eval && cls != ST_UNKNOWN && cls != state && cnt_nxt == CW'(SAMPLE_DB);
  end
`ifdef VMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tcnt;
  logic to_hit;
  assign to_hit = !eval && tcnt == TW'(TIMEOUT_CLKS - 1);
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      tcnt <= '0;
      stale <= 1'b0;
    end else begin
      tcnt <= eval || to_hit ? '0 : tcnt + TW'(1);
      stale <= to_hit ? 1'b1 : eval ? 1'b0 : stale;
    end
  assign fault_set = state == ST_GOOD && (sw || to_hit);
`else
  assign fault_set = state == ST_GOOD && sw;
`endif
  // A band sample re-arms the debouncer on the current state; a stale channel must
  // collect a full fresh run of SAMPLE_DB samples before it is trusted again.
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      state <= ST_UNKNOWN;
      cand <= ST_UNKNOWN;
      cnt <= '0;
    end else if (eval) begin
      cand <= cls == ST_UNKNOWN ? state : cls;
      cnt <= cnt_nxt;
      if (sw) state <= cls;
    end
`ifdef VMON_TIMEOUT_EN
    else if (to_hit) begin
      state <= ST_UNKNOWN;
      cand <= ST_UNKNOWN;
      cnt <= '0;
    end
`endif
endmodule

// File: rtl/sequencer_vmoncompare.sv
// sequencer_vmoncompare: VIN + VRAILS rail UV/OV/good classifier with debounce and sticky fault
// Ports: CLOCK, RESET_N (async, active-low); bus (slave modport) carries ADC levels, FAULT_CLR
//   and all status outputs. Optional stale timeout: define VMON_TIMEOUT_EN.
module sequencer_vmoncompare
  import sequencer_vmoncompare_pkg::*;
#(
  parameter int VRAILS = 4,
  parameter int SAMPLE_DB = 3
`ifdef VMON_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CLKS = 4096
`endif
) (
  input logic CLOCK,
  input logic RESET_N,
  sequencer_vmoncompare_if.slave bus
);
  vmon_state_t st [VRAILS+1];
  logic [VRAILS:0] fset;
  logic [VRAILS-1:0] rail_good, rail_uv, rail_ov;
  logic fault;
`ifdef VMON_TIMEOUT_EN
  logic [VRAILS:0] stale;
  assign bus.ADC_STALE = stale;
`endif
  // Channel 0 is VIN, channel k+1 is rail k.
  for (genvar g = 0; g <= VRAILS; g++) begin : g_ch
    logic [13:0] lvl;
    logic [12:0] uv, ov;
    if (g == 0) begin : g_vin
      assign lvl = bus.ADC_VIN_LEVEL_Q;
      assign uv = P_VIN_UV_TH;
      assign ov = P_VIN_OV_TH;
    end else begin : g_rail
      assign lvl = bus.ADC_VOUT_LEVEL_Q[14*(g-1) +: 14];
      assign uv = P_VOUT_UV_TH[g-1];
      assign ov = P_VOUT_OV_TH[g-1];
    end
    sequencer_vmon_chan #(
      .SAMPLE_DB(SAMPLE_DB)
`ifdef VMON_TIMEOUT_EN
      , .TIMEOUT_CLKS(TIMEOUT_CLKS)
`endif
    ) u_chan (
      .CLOCK(CLOCK),
      .RESET_N(RESET_N),
      .level_q(lvl),
      .uv_th(uv),
      .ov_th(ov),
      .state(st[g]),
      .fault_set(fset[g])
`ifdef VMON_TIMEOUT_EN
      , .stale(stale[g])
`endif
    );
  end
  always_comb begin
    rail_good = '0;
    rail_uv = '0;
    rail_ov = '0;
    for (int i = 0; i < VRAILS; i++) begin
      rail_good[i] = st[i+1] == ST_GOOD;
      rail_uv[i] = st[i+1] == ST_LOW;
      rail_ov[i] = st[i+1] == ST_HIGH;
    end
  end
  // A new fault wins over a same-cycle clear so it is never lost.
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) fault <= 1'b0;
    else fault <= |fset ? 1'b1 : bus.FAULT_CLR ? 1'b0 : fault;
  assign bus.VIN_GOOD = st[0] == ST_GOOD;
  assign bus.VIN_UV = st[0] == ST_LOW;
  assign bus.RAIL_GOOD = rail_good;
  assign bus.RAIL_UV = rail_uv;
  assign bus.RAIL_OV = rail_ov;
  assign bus.FAULT_STICKY = fault;
endmodule
